// File: rtl/pwm_array_peripheral.sv
// Multi-channel PWM peripheral: one shared prescaled period counter and per-channel
// shadowed duty compare, so duty updates only take effect on period boundaries.

module pwm_channel #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 en_out,
    input  logic                 en_pwm,
    input  logic [CNT_WIDTH-1:0] duty,
    input  logic [CNT_WIDTH-1:0] cnt,
    output logic                 out
);
    logic [CNT_WIDTH-1:0] shadow;
    logic                 raw;

    // cnt never exceeds 2^W-2, so an all-ones duty keeps the pin high for the full period
    assign raw = (cnt < shadow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            out    <= 1'b0;
        end else begin
            if (load)
                shadow <= duty;
            out <= en_out & (~en_pwm | raw);
        end
    end
endmodule

module pwm_array_peripheral #(
    parameter int NUM_CH         = 16,
    parameter int CNT_WIDTH      = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             en_out,
    input  logic [NUM_CH-1:0]             en_pwm,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   duty_flat,
    input  logic [PRESCALE_WIDTH-1:0]     prescale,
    output logic [NUM_CH-1:0]             out,
    output logic                          period_start
);
    localparam logic [CNT_WIDTH-1:0] MAX = {{(CNT_WIDTH-1){1'b1}}, 1'b0};

    logic [PRESCALE_WIDTH-1:0]           pre_cnt;
    logic [CNT_WIDTH-1:0]                cnt;
    logic                                loaded;
    logic                                tick;
    logic                                wrap;
    logic                                load;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]    duty_arr;
    logic [NUM_CH-1:0]                   ch_out;

    assign duty_arr = duty_flat;

    // >= rather than == so that lowering prescale mid-count ticks immediately
    assign tick = (pre_cnt >= prescale);
    assign wrap = tick && (cnt == MAX);
    assign load = wrap || !loaded;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt      <= '0;
            cnt          <= '0;
            loaded       <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pre_cnt      <= tick ? '0 : pre_cnt + 1'b1;
            if (tick)
                cnt <= (cnt == MAX) ? '0 : cnt + 1'b1;
            loaded       <= 1'b1;
            period_start <= wrap;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load),
            .en_out (en_out[i]),
            .en_pwm (en_pwm[i]),
            .duty   (duty_arr[i]),
            .cnt    (cnt),
            .out    (ch_out[i])
        );
    end

    assign out = ch_out;
endmodule

// File: tb/tb_pwm_array_peripheral.sv
// Scoreboard bench for pwm_array_peripheral: a period-position reference model predicts
// every cycle's pins; directed measurements check duty ratios and period lengths.

module tb_pwm_array_peripheral;
    localparam int NUM_CH = 16;
    localparam int W      = 8;
    localparam int PW     = 8;
    localparam int PERIOD = (1 << W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_CH-1:0]    en_out;
    logic [NUM_CH-1:0]    en_pwm;
    logic [NUM_CH*W-1:0]  duty_flat;
    logic [PW-1:0]        prescale;
    logic [NUM_CH-1:0]    out;
    logic                 period_start;

    pwm_array_peripheral #(.NUM_CH(NUM_CH), .CNT_WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .duty_flat    (duty_flat),
        .prescale     (prescale),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } dchk_t;

    logic [NUM_CH:0] exp_q[$];
    dchk_t           dq[$];
    int              errors = 0;
    int              checks = 0;

    // Reference model: position within the period advances once per prescaled tick;
    // a channel with captured duty k is high on the first k positions of a period.
    int  m_div;
    int  m_pos;
    int  m_duty[NUM_CH];
    bit  m_primed;
    initial forever begin
        logic [NUM_CH:0] e;
        bit adv, boundary;
        @(posedge clk);
        e = '0;
        if (!rst_n) begin
            m_div = 0; m_pos = 0; m_primed = 0;
            for (int i = 0; i < NUM_CH; i++) m_duty[i] = 0;
        end else begin
            adv      = (m_div >= int'(prescale));
            boundary = adv && (m_pos == PERIOD - 1);
            for (int i = 0; i < NUM_CH; i++)
                e[i] = en_out[i] && (!en_pwm[i] || (m_pos < m_duty[i]));
            e[NUM_CH] = boundary;
            if (boundary || !m_primed)
                for (int i = 0; i < NUM_CH; i++) m_duty[i] = int'(duty_flat[i*W +: W]);
            m_primed = 1;
            m_div = adv ? 0 : m_div + 1;
            if (adv) m_pos = (m_pos + 1) % PERIOD;
        end
        exp_q.push_back(e);
    end

    initial forever begin
        logic [NUM_CH:0] got, want;
        dchk_t d;
        @(posedge clk);
        #1;
        got = {period_start, out};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t got out=%h ps=%b", $time, out, period_start);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL cycle t=%0t out=%h ps=%b expected out=%h ps=%b",
                         $time, got[NUM_CH-1:0], got[NUM_CH], want[NUM_CH-1:0], want[NUM_CH]);
            end
        end
        while (dq.size() > 0) begin
            d = dq.pop_front();
            checks++;
            if (d.act != d.exp) begin
                errors++;
                $display("FAIL %s got=%0d expected=%0d", d.name, d.act, d.exp);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    int hcnt[NUM_CH];

    task automatic dchk(input string n, input int a, input int e);
        dq.push_back('{n, a, e});
    endtask

    task automatic set_all(input logic [W-1:0] v);
        for (int i = 0; i < NUM_CH; i++) duty_flat[i*W +: W] = v;
    endtask

    task automatic wait_ps();
        bit ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (period_start) begin ok = 1; break; end
        end
        if (!ok) dchk("ps_timeout", 0, 1);
    endtask

    task automatic measure(input int n);
        for (int i = 0; i < NUM_CH; i++) hcnt[i] = 0;
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) hcnt[i] += int'(out[i]);
        end
    endtask

    // Cycles from the current point to the next period_start, with ch0 high count.
    task automatic gap_to_ps(output int gap, output int h0);
        gap = 0; h0 = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            gap++;
            h0 += int'(out[0]);
            if (period_start) break;
        end
    endtask

    initial begin
        int gap, h0;
        rst_n = 1'b0; prescale = '0; en_out = '1; en_pwm = '1; set_all(8'h80);
        repeat (3) @(negedge clk);
        dchk("reset_out", int'(out), 0);
        dchk("reset_ps", int'(period_start), 0);
        rst_n = 1'b1;

        wait_ps();
        gap_to_ps(gap, h0);
        dchk("half_period_len", gap, 255);
        dchk("half_high_ch0", h0, 128);
        measure(PERIOD);
        dchk("half_high_ch7", hcnt[7], 128);

        set_all(8'h80);
        duty_flat[0 +: W] = 8'h00; duty_flat[W +: W] = 8'hFF; duty_flat[2*W +: W] = 8'h01;
        wait_ps(); wait_ps();
        measure(PERIOD);
        dchk("edge_duty00", hcnt[0], 0);
        dchk("edge_dutyFF", hcnt[1], 255);
        dchk("edge_duty01", hcnt[2], 1);

        en_out = 16'h0003; en_pwm = 16'h0001; set_all(8'h40);
        wait_ps(); wait_ps();
        measure(PERIOD);
        dchk("mask_pwm_ch0", hcnt[0], 64);
        dchk("mask_static_ch1", hcnt[1], 255);
        dchk("mask_off_ch2", hcnt[2], 0);
        dchk("mask_off_ch15", hcnt[15], 0);
        repeat (5) @(negedge clk);
        en_out[0] = 1'b0; en_pwm[0] = 1'b0;
        @(negedge clk);
        dchk("en_out_off", int'(out[0]), 0);
        en_out[0] = 1'b1;
        @(negedge clk);
        dchk("en_out_static_on", int'(out[0]), 1);
        en_pwm[0] = 1'b1;

        en_out = '1; en_pwm = '1; set_all(8'h20);
        wait_ps(); wait_ps();
        h0 = 0;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            if (k == 15) duty_flat[0 +: W] = 8'hC0;
            h0 += int'(out[0]);
        end
        dchk("glitch_cur_period", h0, 32);
        dchk("glitch_boundary_ps", int'(period_start), 1);
        measure(PERIOD);
        dchk("glitch_next_period", hcnt[0], 192);

        prescale = 8'd3; set_all(8'h80);
        wait_ps(); wait_ps();
        gap_to_ps(gap, h0);
        dchk("presc_period_len", gap, 1020);
        dchk("presc_high_ch0", h0, 512);
        repeat ($urandom_range(40, 1)) @(negedge clk);
        prescale = 8'd0;
        repeat (300) @(negedge clk);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NUM_CH; i++) duty_flat[i*W +: W] = W'($urandom);
            if ($urandom_range(3, 0) == 0) en_out = NUM_CH'($urandom);
            if ($urandom_range(3, 0) == 0) en_pwm = NUM_CH'($urandom);
            if ($urandom_range(4, 0) == 0) prescale = PW'($urandom_range(2, 0));
            repeat ($urandom_range(300, 1)) @(negedge clk);
        end

        prescale = '0; en_out = '1; en_pwm = '1; set_all(8'h80);
        wait_ps(); wait_ps();
        repeat (10) @(negedge clk);
        dchk("pre_reset_out", int'(out), 32'hFFFF);
        #2 rst_n = 1'b0;
        #1;
        dchk("areset_out", int'(out), 0);
        dchk("areset_ps", int'(period_start), 0);
        repeat (2) @(negedge clk);
        set_all(8'h30);
        rst_n = 1'b1;
        wait_ps();
        measure(PERIOD);
        dchk("post_reset_duty", hcnt[3], 48);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pwm_array_peripheral.md
Name: pwm_array_peripheral

Overview:
- Parametrised next-generation PWM peripheral: NUM_CH channels, CNT_WIDTH-bit duty resolution, programmable clock prescaler.
- Sits between the SPI register file and the chip output pins.
- All channels share one period counter; each channel has its own duty cycle and its own output/PWM enables.
- Duty values are shadowed and take effect only at period boundaries, so outputs never glitch on a duty update.

Parameters:
- NUM_CH, 16, number of output channels (1..32).
- CNT_WIDTH, 8, period counter and duty width (4..16).
- PRESCALE_WIDTH, 8, width of the prescale divisor input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en_out  input  NUM_CH  per-channel output enable; 0 forces the pin low.
- en_pwm  input  NUM_CH  per-channel PWM enable; 0 with en_out=1 drives the pin static high.
- duty_flat  input  NUM_CH*CNT_WIDTH  channel i duty = duty_flat[i*CNT_WIDTH +: CNT_WIDTH].
- prescale  input  PRESCALE_WIDTH  counter advances once every prescale+1 clocks.
- out  output  NUM_CH  registered PWM outputs.
- period_start  output  1  one-clock pulse when the period counter wraps to 0.

Behaviour:
- Reset is asynchronous and active-low on rst_n; every flop clears immediately, independent of clk.
- Reset values: out=0, period_start=0, pre_cnt=0, cnt=0, all shadow duties=0, loaded=0.
- MAX = 2^CNT_WIDTH - 2. cnt runs 0..MAX, giving a period of 2^CNT_WIDTH-1 ticks (255 for W=8).
- Prescaler, every clk:
  - if pre_cnt >= prescale: pre_cnt<=0 and tick=1;
  - else pre_cnt<=pre_cnt+1 and tick=0.
  - The >= compare means lowering prescale mid-count never overruns. prescale=0 gives tick every clock.
- On tick: if cnt==MAX then cnt<=0, else cnt<=cnt+1. No tick means cnt holds.
- Shadow load: shadow[i]<=duty(i) for all channels when (tick && cnt==MAX) || !loaded. loaded<=1 on the first clock after reset.
  - So the first period after reset uses the duty present one clock after reset release.
  - Duty changes during a period are ignored until the next wrap. Simultaneous duty write and wrap: the new value is taken.
- raw[i] = (cnt < shadow[i]), unsigned, zero-extended compare.
  - duty=0: always low.
  - duty=all-ones (2^W-1): always high, since cnt never exceeds MAX.
  - duty=k: high for k of the 2^W-1 ticks.
- Output register, every clk:
  - en_out[i]=0: out[i]<=0.
  - en_out[i]=1, en_pwm[i]=0: out[i]<=1.
  - en_out[i]=1, en_pwm[i]=1: out[i]<=raw[i].
  - Latency is 1 clock from cnt/shadow/enable change to out.
  - Enables are not shadowed; they act on the next clock.
- period_start <= tick && cnt==MAX. It is high during the first clock that cnt==0, so it is aligned with the first out cycle of the new period minus one clock of output latency.
- Reset mid-period: all outputs go low at once. Counting restarts from cnt=0 after release, and loaded forces a fresh duty capture.
- prescale change: takes effect from the next pre_cnt compare; cnt phase is preserved.

Test Plan:
- Reset hold, then release with prescale=0, en_out=0xFFFF, en_pwm=0xFFFF, all duties=0x80 -> every out high for exactly 128 of each 255 clocks; period_start pulses every 255 clocks.
- Duty edge values, per channel: ch0=0x00, ch1=0xFF, ch2=0x01 -> ch0 constant 0, ch1 constant 1, ch2 high 1 clock per 255.
- Enable masking: en_out=0x0003, en_pwm=0x0001, duty=0x40 -> ch0 PWM at 64/255, ch1 static 1, ch2..15 static 0; toggling en_out[0] changes out[0] after 1 clock.
- Glitch-free update: write ch0 duty 0x20->0xC0 at cnt=0x10 -> current period stays 32 high; the next period, starting at the period_start pulse, is 192 high.
- Prescaler: prescale=3, duty=0x80 -> period 1020 clocks, high 512; change prescale 3->0 mid-count with pre_cnt=2 -> next tick on the following clock, no wrap-around stall.
- Async reset asserted mid-period with out high -> out=0 and period_start=0 without a clock edge; after release the first period uses the current duty.
